// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-register stages.
// Widths default to the ID/EX packet; other stages override them.
package pipe_pkg;

  localparam int PAYLOAD_W_DEF   = 186;
  localparam int CTRL_W_DEF      = 7;
  localparam int STALL_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int CTRL_SAVE_TO_REG = 0;
  localparam int CTRL_RS1_USED    = 1;
  localparam int CTRL_RS2_USED    = 2;
  localparam int CTRL_IMM_USED    = 3;
  localparam int CTRL_IS_BRANCH   = 4;
  localparam int CTRL_RD_MEM      = 5;
  localparam int CTRL_WR_MEM      = 6;

endpackage

// File: rtl/op_pipe_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Sticks at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/op_pipe_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, stall, flush
// and a saturating backpressure counter.
module op_pipe_stage
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W   = PAYLOAD_W_DEF,
  parameter int CTRL_W      = CTRL_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   stg_clk,
  input  logic                   reset,
  input  logic                   stg_ena,
  input  logic                   stg_x,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_e               state_q;
  logic [PAYLOAD_W-1:0] main_pay_q;
  logic [CTRL_W-1:0]    main_ctl_q;
  logic [PAYLOAD_W-1:0] skid_pay_q;
  logic [CTRL_W-1:0]    skid_ctl_q;

  logic in_xfer;
  logic out_xfer;
  logic stall_inc;

  // Ready comes from registered state only, never from out_ready.
  assign in_ready  = (state_q != ST_FULL) & stg_ena & ~stg_x;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready & stg_ena & ~stg_x;
  assign stall_inc = out_valid & ~out_ready & stg_ena & ~stg_x;

  assign out_payload = main_pay_q;
  assign out_ctrl    = main_ctl_q;

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_pay_q <= '0;
      main_ctl_q <= '0;
      skid_pay_q <= '0;
      skid_ctl_q <= '0;
    end else if (stg_x) begin
      state_q    <= ST_EMPTY;
      main_pay_q <= '0;
      main_ctl_q <= '0;
      skid_pay_q <= '0;
      skid_ctl_q <= '0;
    end else if (stg_ena) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_pay_q <= in_payload;
            main_ctl_q <= in_ctrl;
            state_q    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_pay_q <= in_payload;
            main_ctl_q <= in_ctrl;
          end else if (in_xfer) begin
            skid_pay_q <= in_payload;
            skid_ctl_q <= in_ctrl;
            state_q    <= ST_FULL;
          end else if (out_xfer) begin
            // Draining keeps out_ctrl zero while no packet is held.
            main_ctl_q <= '0;
            state_q    <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_pay_q <= skid_pay_q;
            main_ctl_q <= skid_ctl_q;
            skid_pay_q <= '0;
            skid_ctl_q <= '0;
            state_q    <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk_i (stg_clk),
    .rst_i (reset),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_op_pipe_stage.sv
// Directed self-checking bench for op_pipe_stage.
// Uses a 4-bit stall counter so saturation is reachable.
module tb_op_pipe_stage;

  localparam int PW = 186;
  localparam int CW = 7;
  localparam int SW = 4;

  logic          stg_clk;
  logic          reset;
  logic          stg_ena;
  logic          stg_x;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [CW-1:0] out_ctrl;
  logic [SW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [PW-1:0] P_A5 = {1'b1, 177'd0, 8'hA5};

  op_pipe_stage #(
    .PAYLOAD_W   (PW),
    .CTRL_W      (CW),
    .STALL_CNT_W (SW)
  ) dut (
    .stg_clk     (stg_clk),
    .reset       (reset),
    .stg_ena     (stg_ena),
    .stg_x       (stg_x),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_ctrl     (in_ctrl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_ctrl    (out_ctrl),
    .stall_cnt   (stall_cnt)
  );

  initial stg_clk = 1'b0;
  always #5 stg_clk = ~stg_clk;

  task automatic chk(input string tag,
                     input logic [191:0] obs,
                     input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge stg_clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    stg_ena    = 1'b1;
    stg_x      = 1'b0;
    in_valid   = 1'b0;
    in_payload = '0;
    in_ctrl    = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_valid", 192'(out_valid), 192'(1'b0));
    chk("rst_pay", 192'(out_payload), 192'd0);
    chk("rst_ctrl", 192'(out_ctrl), 192'd0);
    chk("rst_cnt", 192'(stall_cnt), 192'd0);
    reset = 1'b0;
    #1;

    // First packet: one-cycle latency
    in_valid   = 1'b1;
    in_payload = P_A5;
    in_ctrl    = 7'h41;
    out_ready  = 1'b1;
    #1;
    chk("t1_rdy0", 192'(in_ready), 192'(1'b1));
    tick();
    chk("t1_valid", 192'(out_valid), 192'(1'b1));
    chk("t1_pay", 192'(out_payload), 192'(P_A5));
    chk("t1_ctrl", 192'(out_ctrl), 192'(7'h41));
    chk("t1_rdy1", 192'(in_ready), 192'(1'b1));
    in_valid = 1'b0;
    tick();
    chk("t1_drain_v", 192'(out_valid), 192'(1'b0));
    chk("t1_drain_c", 192'(out_ctrl), 192'd0);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      in_valid   = 1'b1;
      in_payload = PW'(i);
      in_ctrl    = CW'(i);
      tick();
      chk($sformatf("strm_v%0d", i), 192'(out_valid), 192'(1'b1));
      chk($sformatf("strm_p%0d", i), 192'(out_payload), 192'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("strm_end_v", 192'(out_valid), 192'(1'b0));
    chk("strm_cnt", 192'(stall_cnt), 192'd0);

    // Backpressure fills the skid buffer
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = PW'(1);
    in_ctrl    = 7'h01;
    tick();
    in_payload = PW'(2);
    in_ctrl    = 7'h02;
    tick();
    in_payload = PW'(3);
    in_ctrl    = 7'h03;
    #1;
    chk("bp_full_rdy", 192'(in_ready), 192'(1'b0));
    tick();
    chk("bp_hold_p1", 192'(out_payload), 192'd1);
    chk("bp_cnt2", 192'(stall_cnt), 192'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_p2", 192'(out_payload), 192'd2);
    chk("bp_c2", 192'(out_ctrl), 192'(7'h02));
    chk("bp_rdy_one", 192'(in_ready), 192'(1'b1));
    tick();
    chk("bp_p3", 192'(out_payload), 192'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 192'(out_valid), 192'(1'b0));
    chk("bp_cnt_end", 192'(stall_cnt), 192'd2);

    // Flush from FULL drops everything
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = PW'(8'h11);
    in_ctrl    = 7'h7F;
    tick();
    in_payload = PW'(8'h22);
    tick();
    stg_x      = 1'b1;
    in_payload = PW'(8'h33);
    #1;
    chk("fl_rdy_x", 192'(in_ready), 192'(1'b0));
    tick();
    stg_x    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_valid", 192'(out_valid), 192'(1'b0));
    chk("fl_ctrl", 192'(out_ctrl), 192'd0);
    chk("fl_pay", 192'(out_payload), 192'd0);
    chk("fl_rdy", 192'(in_ready), 192'(1'b1));
    chk("fl_cnt", 192'(stall_cnt), 192'd3);
    in_valid   = 1'b1;
    in_payload = PW'(8'h44);
    in_ctrl    = 7'h04;
    tick();
    chk("fl_next", 192'(out_payload), 192'(8'h44));
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("fl_drain", 192'(out_valid), 192'(1'b0));

    // Stage enable low freezes everything
    in_valid   = 1'b1;
    in_payload = PW'(8'h55);
    in_ctrl    = 7'h05;
    tick();
    stg_ena    = 1'b0;
    in_payload = PW'(8'h66);
    in_ctrl    = 7'h06;
    #1;
    chk("en_rdy", 192'(in_ready), 192'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("en_v%0d", i), 192'(out_valid), 192'(1'b1));
      chk($sformatf("en_p%0d", i), 192'(out_payload), 192'(8'h55));
    end
    chk("en_cnt", 192'(stall_cnt), 192'd3);
    stg_ena = 1'b1;
    #1;
    chk("en_rdy1", 192'(in_ready), 192'(1'b1));
    tick();
    chk("en_resume", 192'(out_payload), 192'(8'h66));
    in_valid = 1'b0;
    tick();
    chk("en_drain", 192'(out_valid), 192'(1'b0));

    // Counter saturation, then async reset in FULL
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = PW'(8'h77);
    in_ctrl    = 7'h07;
    tick();
    in_payload = PW'(8'h88);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_cnt", 192'(stall_cnt), 192'(4'hF));
    chk("sat_p", 192'(out_payload), 192'(8'h77));
    chk("sat_rdy", 192'(in_ready), 192'(1'b0));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 192'(out_valid), 192'(1'b0));
    chk("arst_cnt", 192'(stall_cnt), 192'd0);
    chk("arst_pay", 192'(out_payload), 192'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("arst_rdy", 192'(in_ready), 192'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_pipe_stage.md
Name: op_pipe_stage

Overview:
- Parametrised elastic successor to the fixed ID/EX operand latch.
- Registers one instruction packet (payload plus control bits) between two pipeline stages, with a valid/ready handshake and a 2-entry skid buffer, so the upstream ready never depends combinationally on downstream ready.
- Supports global stage enable (stall), flush/kill (bubble insertion) and a saturating backpressure counter.
- Instantiated between decode and execute, and reusable for EX/MEM and MEM/WB.

Parameters:
- PAYLOAD_W, 186: data width (pc, rs1/rs2/rd indices, funct, imm, opcode, rs1/rs2 data).
- CTRL_W, 7: control bits cleared on flush (save_to_reg, rs1_used, rs2_used, immediate_used, is_branch, rd_memory, wr_memory).
- STALL_CNT_W, 16: width of the backpressure counter.

Ports:
- stg_clk, input, 1: stage clock; single clock domain.
- reset, input, 1: asynchronous, active-high reset.
- stg_ena, input, 1: stage enable; low freezes all state.
- stg_x, input, 1: flush/kill; drops all held packets.
- in_valid, input, 1: upstream packet valid.
- in_ready, output, 1: stage can accept a packet.
- in_payload, input, PAYLOAD_W: upstream data.
- in_ctrl, input, CTRL_W: upstream control bits.
- out_valid, output, 1: packet available downstream.
- out_ready, input, 1: downstream accepts.
- out_payload, output, PAYLOAD_W: registered data.
- out_ctrl, output, CTRL_W: registered control; all-zero when out_valid=0.
- stall_cnt, output, STALL_CNT_W: saturating count of backpressure cycles.

Behaviour:
- Reset (async, active-high): state EMPTY; out_valid=0, out_payload=0, out_ctrl=0, skid contents=0, stall_cnt=0. Reset mid-transfer discards both entries.
- Storage: main register drives the outputs; skid register holds the overflow entry.
- States: EMPTY (none valid), ONE (main valid), FULL (main+skid valid).
- in_ready = (state!=FULL) & stg_ena & ~stg_x. Depends on registered state only; no path from out_ready.
- Input transfer: in_xfer = in_valid & in_ready.
- Output transfer: out_xfer = out_valid & out_ready & stg_ena & ~stg_x.
- EMPTY:
  - in_xfer -> ONE, main<=in.
  - else hold.
- ONE:
  - in_xfer & out_xfer -> ONE, main<=in.
  - in_xfer & ~out_xfer -> FULL, skid<=in.
  - ~in_xfer & out_xfer -> EMPTY.
  - else hold.
- FULL:
  - out_xfer -> ONE, main<=skid, skid cleared.
  - else hold. in_ready=0.
- Latency: 1 cycle from in_xfer into EMPTY to out_valid. Steady-state throughput 1 packet/cycle.
- stg_ena=0: no state, data or counter change; in_ready=0. out_valid and out_* hold their values.
- stg_x=1 (any state, any stg_ena):
  - Next state EMPTY; main and skid payload/ctrl cleared to 0.
  - Flush has priority over enable, in_xfer and out_xfer; the packet presented that cycle is dropped.
- Simultaneous stg_x and reset: reset dominates (async).
- stall_cnt: increments when out_valid & ~out_ready & stg_ena & ~stg_x; saturates at all-ones; cleared only by reset.
- Payload and ctrl are passed unmodified; no width conversion or arithmetic.

Decomposition:
- Shared package pipe_pkg:
  - State encoding ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Ctrl bit indices CTRL_SAVE_TO_REG=0, CTRL_RS1_USED=1, CTRL_RS2_USED=2, CTRL_IMM_USED=3, CTRL_IS_BRANCH=4, CTRL_RD_MEM=5, CTRL_WR_MEM=6.
  - Default widths.
- One natural sub-module: sat_counter (parametrised width, inc enable, async reset), used for stall_cnt.

Test Plan:
- Reset, then in_valid=1, in_payload=0x...A5, in_ctrl=7'h41, out_ready=1, stg_ena=1 -> next cycle out_valid=1, out_payload=0x...A5, out_ctrl=7'h41, in_ready=1 throughout.
- Stream 8 packets (payload 1..8) with out_ready=1 -> outputs 1..8 in order on consecutive cycles, no bubbles, stall_cnt=0.
- Send packets 1,2,3 with out_ready=0 -> after 2 accepts in_ready=0 (FULL); packet 3 stalls upstream. Raise out_ready -> outputs 1,2,3 in order. stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- FULL, then stg_x=1 for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_payload=0; the input packet is not captured. Following cycle in_ready=1.
- ONE with payload 0x55, stg_ena=0 for 3 cycles, out_ready=1, in_valid=1 -> out_payload stays 0x55, state unchanged, stall_cnt unchanged. stg_ena=1 -> transfer resumes.
- STALL_CNT_W=4, hold backpressure 20 cycles -> stall_cnt saturates at 4'hF. Assert reset mid-FULL -> out_valid=0 and stall_cnt=0 immediately (async).
